steer_byte_serializer: RTL and testbench

Downstream stage of the steering module (`SM`). It captures the eight 8-bit steering lanes as one 64-bit word on a valid/ready handshake and buffers them in a small FIFO. It then emits the buffered data one byte per cycle on a valid/ready output stream, flagging the last byte of each word. This decouples the parallel steering outputs from the narrow byte-wide consumer further down the datapath.

---
 rtl/steer_byte_serializer.sv | 145 ++++++++++++++
 tb/tb_steer_byte_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/steer_byte_serializer.sv
// Captures the eight steering lanes as one word into a small FIFO and replays
// them one byte per cycle, lane 1 first, flagging lane 8 as the last byte.
module steer_byte_serializer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       In1,
    input  logic [7:0]       In2,
    input  logic [7:0]       In3,
    input  logic [7:0]       In4,
    input  logic [7:0]       In5,
    input  logic [7:0]       In6,
    input  logic [7:0]       In7,
    input  logic [7:0]       In8,
    input  logic [2:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic [2:0]       out_tag,
    output logic [CNT_W-1:0] words_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 67;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_addr;
    logic [CW-1:0]    count_reg, count_next;
    logic             in_ready_reg;
    state_t           state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic [63:0]      word_reg;
    logic [2:0]       tag_reg;
    logic [CNT_W-1:0] words_done_reg;
    logic             push, pop, load_head, load_next;
    logic [7:0]       word_lanes [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign word_lanes[gi] = word_reg[gi*8 +: 8];
        end
    endgenerate

    assign push = in_valid && in_ready_reg;
    assign pop  = (state_reg == SEND) && out_ready && (idx_reg == 3'd7);

    // The head stays in the FIFO until its last byte is accepted, so the
    // follow-on word sits one slot past the read pointer.
    assign rd_addr = load_next ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load_head  = 1'b0;
        load_next  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    load_head  = 1'b1;
                    idx_next   = 3'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (idx_reg == 3'd7);
                if (out_ready) begin
                    if (idx_reg != 3'd7) begin
                        idx_next = idx_reg + 3'd1;
                    end else begin
                        idx_next = 3'd0;
                        if (count_reg > CW'(1)) begin
                            load_next = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_tag, In8, In7, In6, In5, In4, In3, In2, In1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= 3'd0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            in_ready_reg   <= 1'b0;
            words_done_reg <= '0;
            word_reg       <= '0;
            tag_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            count_reg    <= count_next;
            in_ready_reg <= (count_next < DEPTH_C);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + PW'(1);
                words_done_reg <= words_done_reg + CNT_W'(1);
            end
            if (load_head || load_next) begin
                {tag_reg, word_reg} <= mem[rd_addr];
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_byte   = (state_reg == SEND) ? word_lanes[idx_reg] : 8'h00;
    assign out_tag    = (state_reg == SEND) ? tag_reg : 3'd0;
    assign words_done = words_done_reg;

endmodule

// File: tb/tb_steer_byte_serializer.sv
// Directed bench for steer_byte_serializer: pushed words feed a byte scoreboard
// that is checked against every accepted output byte.
module tb_steer_byte_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] In1, In2, In3, In4, In5, In6, In7, In8;
    logic [2:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic [2:0] out_tag;
    logic [3:0] words_done;

    always #5 clock = ~clock;

    steer_byte_serializer #(.DEPTH(2), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .In1(In1), .In2(In2), .In3(In3), .In4(In4),
        .In5(In5), .In6(In6), .In7(In7), .In8(In8),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .out_tag(out_tag),
        .words_done(words_done)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic [2:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_done = 0;
    int          cyc      = 0;
    logic        last_accept = 1'b0;
    logic        stall_prev  = 1'b0;
    logic [7:0]  held_byte;
    logic        held_last;
    logic [2:0]  held_tag;
    logic [63:0] cur_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input logic [63:0] w, input logic [2:0] t);
        cur_word = w;
        {In8, In7, In6, In5, In4, In3, In2, In1} = w;
        in_tag   = t;
        in_valid = 1'b1;
    endtask

    // Sample at the falling edge, update the scoreboard, advance one cycle.
    task automatic tick();
        logic acc;
        exp_t e;
        acc = 1'b0;
        if (!reset) begin
            chk("words_done", {28'd0, words_done}, {28'd0, 4'(exp_done)});
            if (stall_prev) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_byte", {24'd0, out_byte}, {24'd0, held_byte});
                chk("stall_last", {31'd0, out_last}, {31'd0, held_last});
                chk("stall_tag", {29'd0, out_tag}, {29'd0, held_tag});
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_byte", {24'd0, out_byte}, {24'd0, e.b});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    chk("out_tag", {29'd0, out_tag}, {29'd0, e.tag});
                    if (e.last) exp_done++;
                end
                $display("cyc %0d: out byte=0x%02h last=%0b tag=%0d", cyc, out_byte, out_last, out_tag);
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    e.b    = cur_word[i*8 +: 8];
                    e.last = (i == 7);
                    e.tag  = in_tag;
                    sb.push_back(e);
                end
                $display("cyc %0d: push word=0x%016h tag=%0d", cyc, cur_word, in_tag);
            end
            stall_prev = out_valid && !out_ready;
            held_byte  = out_byte;
            held_last  = out_last;
            held_tag   = out_tag;
        end else begin
            stall_prev = 1'b0;
        end
        cyc++;
        @(negedge clock);
        if (acc) in_valid = 1'b0;
        last_accept = acc;
    endtask

    task automatic push_word(input logic [63:0] w, input logic [2:0] t);
        drive_word(w, t);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (last_accept) break;
        end
        chk("push_accept", {31'd0, last_accept}, 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_tag", {29'd0, out_tag}, 32'd0);
        chk("rst_words_done", {28'd0, words_done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        int run;
        int w1_last;
        int w3_acc;
        logic [3:0] pat;
        logic [63:0] rw;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tag = 3'd0;
        {In8, In7, In6, In5, In4, In3, In2, In1} = 64'd0;
        cur_word = 64'd0;
        repeat (3) @(negedge clock);
        chk_reset_vals();
        reset = 1'b0;
        tick();
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Single word with zero lanes, consumer always ready.
        out_ready = 1'b1;
        push_word(64'hFF00_0000_0000_0F10, 3'd0);
        tick();
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_lane1", {24'd0, out_byte}, 32'h10);
        drain(40);
        chk("s1_words_done", {28'd0, words_done}, 32'd1);

        // Fill the two-deep FIFO while stalled, hold a third word upstream.
        out_ready = 1'b0;
        push_word(64'h8877_6655_4433_2211, 3'd1);
        push_word(64'h2827_2625_2423_2221, 3'd2);
        chk("in_ready_full", {31'd0, in_ready}, 32'd0);
        drive_word(64'h3837_3635_3433_3231, 3'd3);
        repeat (4) begin
            tick();
            chk("w3_held", {31'd0, last_accept}, 32'd0);
        end

        // Drain all three: one gap-free run of 24 bytes.
        out_ready = 1'b1;
        run = 0; w1_last = -1; w3_acc = -1;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) run++;
            else if (run > 0) break;
            if (out_valid && out_last && w1_last < 0) w1_last = cyc;
            tick();
            if (last_accept && w3_acc < 0) w3_acc = cyc - 1;
        end
        chk("w3_after_pop", w3_acc, w1_last + 1);
        chk("no_bubble_run", run, 32'd24);
        chk("s3_words_done", {28'd0, words_done}, 32'd4);
        chk("s3_sb_empty", sb.size(), 32'd0);

        // Stall pattern 1,0,0,1 across one word.
        out_ready = 1'b0;
        push_word(64'hA8A7_A6A5_A4A3_A2A1, 3'd5);
        pat = 4'b1001;
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            out_ready = pat[i % 4];
            tick();
        end
        chk("toggle_sb_empty", sb.size(), 32'd0);
        chk("toggle_words_done", {28'd0, words_done}, 32'd5);

        // Reset after the fourth byte of a word.
        out_ready = 1'b1;
        push_word(64'hB8B7_B6B5_B4B3_B2B1, 3'd6);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() <= 4) break;
            tick();
        end
        chk("four_bytes_out", sb.size(), 32'd4);
        reset = 1'b1;
        tick();
        chk_reset_vals();
        sb.delete();
        exp_done = 0;
        reset = 1'b0;
        tick();
        push_word(64'hC8C7_C6C5_C4C3_C2C1, 3'd7);
        tick();
        chk("post_reset_lane1", {24'd0, out_byte}, 32'hC1);
        drain(40);
        chk("post_reset_words_done", {28'd0, words_done}, 32'd1);

        // Sixteen more words bring the 4-bit counter to 17 mod 16.
        for (int k = 0; k < 16; k++) begin
            rw = {$urandom, $urandom} & {$urandom, $urandom};
            push_word(rw, 3'($urandom_range(0, 7)));
        end
        drain(300);
        chk("wrap_words_done", {28'd0, words_done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
